// File: rtl/master_req_queue.sv
// Small generic FIFO with registered occupancy count; storage clears on reset so the head reads zero.
// Zero-latency head (read port is combinational); push is ignored while full, pop is ignored while empty.
module mrq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Request queue and issue sequencer feeding master_port; first dvalid 2 cycles after a push into an idle queue,
// at most one transaction outstanding (>= 4 cycles apart); req_ready = !full from the registered count, requester holds.
module master_req_queue #(
  parameter int  ADDR_WIDTH = 16,
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_mode,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic [PTR_W:0]        q_count,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mode;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_DONE
  } state_t;

  state_t state;
  req_t   in_req;
  req_t   head;
  logic   fifo_full;
  logic   push_acc;
  logic   pop_head;
  logic   more_work;
  logic   hi_seen;

  assign in_req.addr  = req_addr;
  assign in_req.wdata = req_wdata;
  assign in_req.mode  = req_mode;

  assign req_ready = !fifo_full;
  assign push_acc  = req_valid && req_ready;
  assign pop_head  = (state == S_DONE);
  // In DONE the head is still counted: work remains if more than one entry is stored or one arrives now.
  assign more_work = (q_count[PTR_W:1] != '0) || push_acc;

  assign dwdata = head.wdata;
  assign daddr  = head.addr;
  assign dmode  = head.mode;

  mrq_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push_vld (push_acc),
    .push_dat (in_req),
    .pop      (pop_head),
    .head_dat (head),
    .count    (q_count),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      dvalid    <= 1'b0;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      rsp_rdata <= '0;
      hi_seen   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (q_count != '0) begin
            state  <= S_ISSUE;
            dvalid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (dready) begin
            state   <= S_WAIT_LO;
            dvalid  <= 1'b0;
            hi_seen <= 1'b0;
          end
        end
        S_WAIT_LO: begin
          if (!dready) begin
            state <= S_WAIT_HI;
          end else if (!hi_seen) begin
            hi_seen <= 1'b1;
          end else begin
            // Port never showed busy: it finished immediately, so its read data is already valid.
            state     <= S_DONE;
            rsp_valid <= !head.mode;
            wr_done   <= head.mode;
            if (!head.mode) rsp_rdata <= drdata;
          end
        end
        S_WAIT_HI: begin
          if (dready) begin
            state     <= S_DONE;
            rsp_valid <= !head.mode;
            wr_done   <= head.mode;
            if (!head.mode) rsp_rdata <= drdata;
          end
        end
        S_DONE: begin
          if (more_work) begin
            state  <= S_ISSUE;
            dvalid <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          dvalid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_master_req_queue.sv
// Bench for master_req_queue: directed pushes, a behavioural master_port, and a scoreboard monitor.
module tb_master_req_queue;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_mode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, wr_done;
  logic [DW-1:0] rsp_rdata;
  logic [PTR_W:0] q_count;
  logic [DW-1:0] dwdata, drdata;
  logic [AW-1:0] daddr;
  logic          dmode, dvalid, dready;

  master_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done), .q_count(q_count),
    .dwdata(dwdata), .daddr(daddr), .dmode(dmode), .dvalid(dvalid),
    .dready(dready), .drdata(drdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic mode; } req_t;
  typedef struct packed { logic is_wr; logic [DW-1:0] data; } resp_t;

  req_t          exp_issue_q[$];
  resp_t         exp_resp_q[$];
  int            lat_q[$];
  logic [DW-1:0] rdq[$];
  int            checks = 0;
  int            errors = 0;
  bit            hs_seen = 1'b0;
  bit            hold_low = 1'b0;
  time           done_t = 0;

  logic [AW-1:0] t4_addr [10] = '{16'h4000, 16'h41F0, 16'h4202, 16'h43A4, 16'h4410,
                                  16'h4577, 16'h46C8, 16'h4701, 16'h48FE, 16'h4933};
  logic [DW-1:0] t4_dat  [10] = '{8'h01, 8'h9D, 8'h44, 8'h7E, 8'hB2, 8'h08, 8'hF0, 8'h6B, 8'h2C, 8'hD7};
  logic          t4_mode [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int            t4_lat  [10] = '{2, 30, 7, 13, 2, 21, 5, 9, 30, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_req(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic m,
                            input logic [DW-1:0] rd, input int lat);
    req_t  e;
    resp_t r;
    e.addr = a; e.wdata = wd; e.mode = m;
    r.is_wr = m; r.data = rd;
    exp_issue_q.push_back(e);
    exp_resp_q.push_back(r);
    lat_q.push_back(lat);
    rdq.push_back(rd);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic m,
                      input logic [DW-1:0] rd, input int lat, output time acc_t);
    bit acc = 1'b0;
    acc_t = 0;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_mode = m;
    for (int i = 0; i < 3000 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      acc_t = $time;
      #1;
    end
    req_valid = 1'b0;
    chk("push_accepted", 32'(acc), 1);
    if (acc) expect_req(a, wd, m, rd, lat);
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = (q_count == '0) && !dvalid;
    end
    chk({tag, "_idle"}, 32'(idle), 1);
    chk({tag, "_resp_drained"}, 32'(exp_resp_q.size()), 0);
    chk({tag, "_issue_drained"}, 32'(exp_issue_q.size()), 0);
  endtask

  // master_port model: idle => dready high; busy for 'lat' cycles after acceptance; drdata valid on return.
  initial begin : master_model
    int            lat_left;
    logic [DW-1:0] cur;
    bit            busy;
    busy = 1'b0; lat_left = 0; cur = '0;
    dready = 1'b1; drdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        busy = 1'b0;
        dready = 1'b1;
      end else if (busy) begin
        if (lat_left == 0) begin
          dready = 1'b1;
          drdata = cur;
          busy = 1'b0;
        end else begin
          lat_left--;
        end
      end else if (hs_seen) begin
        dready = 1'b0;
        drdata = 8'hEE;
        busy = 1'b1;
        lat_left = (lat_q.size() != 0) ? lat_q.pop_front() - 1 : 0;
        cur = (rdq.size() != 0) ? rdq.pop_front() : '0;
      end else begin
        dready = !hold_low;
      end
    end
  end

  initial begin : monitor
    req_t  e;
    resp_t r;
    forever begin
      @(negedge clk);
      hs_seen = 1'b0;
      if (rstn) begin
        if (dvalid && dready) begin
          hs_seen = 1'b1;
          chk("issue_expected", 32'(exp_issue_q.size() != 0), 1);
          if (exp_issue_q.size() != 0) begin
            e = exp_issue_q.pop_front();
            chk("issue_addr", 32'(daddr), 32'(e.addr));
            chk("issue_mode", 32'(dmode), 32'(e.mode));
            if (e.mode) chk("issue_wdata", 32'(dwdata), 32'(e.wdata));
          end
        end
        if (rsp_valid || wr_done) begin
          done_t = $time;
          chk("resp_expected", 32'(exp_resp_q.size() != 0), 1);
          if (exp_resp_q.size() != 0) begin
            r = exp_resp_q.pop_front();
            chk("resp_kind", 32'({rsp_valid, wr_done}), r.is_wr ? 32'd1 : 32'd2);
            if (!r.is_wr) chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    time t, t5;
    bit  found;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_mode = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #21;
    chk("rst_dvalid", 32'(dvalid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_wr_done", 32'(wr_done), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_daddr", 32'(daddr), 0);
    chk("rst_dwdata", 32'(dwdata), 0);
    chk("rst_dmode", 32'(dmode), 0);
    chk("rst_q_count", 32'(q_count), 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 1);

    // Single read: dvalid appears on the second cycle after the push.
    push(16'h1234, 8'h00, 1'b0, 8'hA5, 20, t);
    chk("t1_dvalid_c1", 32'(dvalid), 0);
    chk("t1_count", 32'(q_count), 1);
    @(posedge clk); #1;
    chk("t1_dvalid_c2", 32'(dvalid), 1);
    chk("t1_daddr", 32'(daddr), 32'h1234);
    chk("t1_dmode", 32'(dmode), 0);
    wait_idle("t1");
    chk("t1_rdata", 32'(rsp_rdata), 32'hA5);

    // Single write: rsp_rdata keeps the previous read value.
    push(16'h2010, 8'h3C, 1'b1, 8'h00, 5, t);
    wait_idle("t2");
    chk("t2_rdata_hold", 32'(rsp_rdata), 32'hA5);

    // Fill with the port stalled; the fifth request waits until the cycle after the first DONE.
    hold_low = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(16'h3000, 8'h11, 1'b1, 8'h00, 3, t);
    push(16'h3004, 8'h00, 1'b0, 8'h5A, 4, t);
    push(16'h3008, 8'h22, 1'b1, 8'h00, 2, t);
    push(16'h300C, 8'h00, 1'b0, 8'hC3, 6, t);
    chk("t3_full_ready", 32'(req_ready), 0);
    chk("t3_full_count", 32'(q_count), 4);
    chk("t3_head_held", 32'(daddr), 32'h3000);
    fork
      push(16'h3010, 8'h00, 1'b0, 8'h96, 2, t5);
      begin
        repeat (3) @(posedge clk);
        #2 hold_low = 1'b0;
      end
    join
    chk("t3_fifth_after_done", 32'(t5 - done_t), 15);
    wait_idle("t3");

    // Mixed traffic with varied latency, wrapping the pointers several times.
    for (int i = 0; i < 10; i++) push(t4_addr[i], t4_dat[i], t4_mode[i], t4_dat[i], t4_lat[i], t);
    wait_idle("t4");

    // Push in the DONE cycle at count=2: count holds and the second entry issues next.
    push(16'h5000, 8'h00, 1'b0, 8'h81, 10, t);
    push(16'h5004, 8'h5E, 1'b1, 8'h00, 4, t);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = rsp_valid || wr_done;
    end
    chk("t5_done_seen", 32'(found), 1);
    chk("t5_ready_in_done", 32'(req_ready), 1);
    req_valid = 1'b1; req_addr = 16'h5008; req_wdata = 8'h00; req_mode = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_req(16'h5008, 8'h00, 1'b0, 8'h3D, 6);
    chk("t5_count_stay", 32'(q_count), 2);
    chk("t5_next_dvalid", 32'(dvalid), 1);
    chk("t5_next_daddr", 32'(daddr), 32'h5004);
    wait_idle("t5");

    // Reset while the first of three entries waits in WAIT_HI.
    push(16'h6000, 8'h00, 1'b0, 8'h42, 25, t);
    push(16'h6001, 8'h77, 1'b1, 8'h00, 3, t);
    push(16'h6002, 8'h00, 1'b0, 8'h24, 3, t);
    repeat (5) @(posedge clk);
    #2;
    chk("t6_count_pre", 32'(q_count), 3);
    rstn = 1'b0;
    #1;
    chk("t6_dvalid", 32'(dvalid), 0);
    chk("t6_q_count", 32'(q_count), 0);
    chk("t6_rsp_rdata", 32'(rsp_rdata), 0);
    chk("t6_daddr", 32'(daddr), 0);
    exp_issue_q.delete(); exp_resp_q.delete(); lat_q.delete(); rdq.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_post_dvalid", 32'(dvalid), 0);
    chk("t6_post_ready", 32'(req_ready), 1);
    push(16'h7000, 8'h00, 1'b0, 8'h99, 3, t);
    wait_idle("t6");
    chk("t6_post_rdata", 32'(rsp_rdata), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
